glb_router_injector: RTL and testbench

Injection stage that feeds a mesh router's source port from a global-buffer (GLB) bank. Words from the GLB are buffered in a small FIFO. Each word is released into the router as a registered data/enable pair. Per-burst configuration sets the router's routing mode, which is held stable for the whole burst and changes only while enable is low. One instance sits in front of the north source port of each router in a cluster.

---
 rtl/glb_router_injector_if.sv | 35 +++
 rtl/glb_router_injector.sv | 95 +++++++++
 tb/tb_glb_router_injector.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/glb_router_injector_if.sv
// Bundle between a GLB bank, the injector and the router source port.
// The master side is the GLB/router environment; the slave side is the injector.
interface glb_router_injector_if #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_WIDTH  = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                  cfg_valid_i;
   logic [3:0]            cfg_mode_i;
   logic [LEN_WIDTH-1:0]  cfg_len_i;
   logic                  cfg_ready_o;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  data_valid_i;
   logic                  data_ready_o;
   logic                  stall_i;
   logic [3:0]            router_mode_o;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  enable_o;
   logic                  busy_o;
   logic [CW-1:0]         fifo_count_o;

   modport master (
      output cfg_valid_i, cfg_mode_i, cfg_len_i, data_i, data_valid_i, stall_i,
      input  cfg_ready_o, data_ready_o, router_mode_o, data_o, enable_o, busy_o,
             fifo_count_o
   );

   modport slave (
      input  cfg_valid_i, cfg_mode_i, cfg_len_i, data_i, data_valid_i, stall_i,
      output cfg_ready_o, data_ready_o, router_mode_o, data_o, enable_o, busy_o,
             fifo_count_o
   );
endinterface

// File: rtl/glb_router_injector.sv
// GLB-to-router injection stage: word FIFO plus a burst FSM that holds the
// router mode stable for a whole burst and emits one registered word per pop.
module glb_router_injector #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input logic                clk,
   input logic                reset,
   glb_router_injector_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SETUP, SEND} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic [LEN_WIDTH-1:0]  words_left;
   logic                  push, pop, cfg_start, last_pop;

   // Full blocks pushes even when a pop happens in the same cycle.
   assign push      = bus.data_valid_i && (count != CNT_FULL);
   assign pop       = (state == SEND) && (count != '0) && !bus.stall_i;
   assign cfg_start = bus.cfg_valid_i && (state == IDLE) && (bus.cfg_len_i != '0);
   assign last_pop  = pop && (words_left == LEN_WIDTH'(1));

   assign bus.data_ready_o = (count != CNT_FULL);
   assign bus.fifo_count_o = count;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: defaults first so no path through the case leaves a latch behind.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_start) state_nxt = SETUP;
         SETUP:   state_nxt = SEND;
         SEND:    if (last_pop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.cfg_ready_o = (state == IDLE);
      bus.busy_o      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.router_mode_o <= '0;
         bus.data_o        <= '0;
         bus.enable_o      <= 1'b0;
         words_left        <= '0;
      end else begin
         bus.enable_o <= pop;
         if (pop) bus.data_o <= mem[rd_ptr];
         if (cfg_start) begin
            bus.router_mode_o <= bus.cfg_mode_i;
            words_left        <= bus.cfg_len_i;
         end else if (pop) begin
            words_left <= words_left - LEN_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_glb_router_injector.sv
// Directed bench for glb_router_injector: bursts, full FIFO, stalls,
// zero-length descriptors, back-to-back bursts and mid-burst reset.
module tb_glb_router_injector;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   glb_router_injector_if #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .LEN_WIDTH(8)) bus ();

   glb_router_injector #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .LEN_WIDTH(8)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] d);
      bus.data_i       = d;
      bus.data_valid_i = 1'b1;
      tick();
      bus.data_valid_i = 1'b0;
   endtask

   task automatic send_cfg(input logic [3:0] mode, input logic [7:0] len);
      bus.cfg_valid_i = 1'b1;
      bus.cfg_mode_i  = mode;
      bus.cfg_len_i   = len;
      tick();
      bus.cfg_valid_i = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      bus.cfg_valid_i  = 1'b0;
      bus.cfg_mode_i   = '0;
      bus.cfg_len_i    = '0;
      bus.data_i       = '0;
      bus.data_valid_i = 1'b0;
      bus.stall_i      = 1'b0;
      reset            = 1'b1;
      tick();
      tick();

      // Reset state
      check("rst_busy",   32'(bus.busy_o), 0);
      check("rst_cfgrdy", 32'(bus.cfg_ready_o), 1);
      check("rst_datrdy", 32'(bus.data_ready_o), 1);
      check("rst_count",  32'(bus.fifo_count_o), 0);
      check("rst_en",     32'(bus.enable_o), 0);
      check("rst_mode",   32'(bus.router_mode_o), 0);
      check("rst_data",   32'(bus.data_o), 0);
      reset = 1'b0;

      // Basic burst: 4 words, SOUTH
      for (int i = 0; i < 4; i++) push_word(16'('h11 + i));
      check("b1_count", 32'(bus.fifo_count_o), 4);
      send_cfg(4'd2, 8'd4);
      check("b1_mode",   32'(bus.router_mode_o), 2);
      check("b1_busy",   32'(bus.busy_o), 1);
      check("b1_cfgrdy", 32'(bus.cfg_ready_o), 0);
      check("b1_en_setup", 32'(bus.enable_o), 0);
      tick();
      check("b1_en_e1", 32'(bus.enable_o), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("b1_en",   32'(bus.enable_o), 1);
         check("b1_data", 32'(bus.data_o), 'h11 + i);
         check("b1_busy_run", 32'(bus.busy_o), (i == 3) ? 0 : 1);
      end
      tick();
      check("b1_en_after", 32'(bus.enable_o), 0);
      check("b1_data_hold", 32'(bus.data_o), 'h14);
      check("b1_count_end", 32'(bus.fifo_count_o), 0);

      // Full FIFO: 8 words, 9th refused
      for (int i = 0; i < 8; i++) push_word(16'('h100 + i));
      check("full_count",  32'(bus.fifo_count_o), 8);
      check("full_datrdy", 32'(bus.data_ready_o), 0);
      bus.data_i       = 16'h1ff;
      bus.data_valid_i = 1'b1;
      tick();
      check("full_9th_count", 32'(bus.fifo_count_o), 8);
      check("full_9th_rdy",   32'(bus.data_ready_o), 0);
      bus.data_valid_i = 1'b0;
      send_cfg(4'd1, 8'd8);
      check("full_mode", 32'(bus.router_mode_o), 1);
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         check("full_en",   32'(bus.enable_o), 1);
         check("full_data", 32'(bus.data_o), 'h100 + i);
         if (i == 0) check("full_datrdy_pop", 32'(bus.data_ready_o), 1);
      end
      check("full_busy_end", 32'(bus.busy_o), 0);
      check("full_count_end", 32'(bus.fifo_count_o), 0);

      // Stalled burst: len 5, stall on 2nd and 3rd SEND cycles
      for (int i = 0; i < 5; i++) push_word(16'('h21 + i));
      send_cfg(4'd6, 8'd5);
      check("st_mode", 32'(bus.router_mode_o), 6);
      tick();
      tick();
      check("st_en0",   32'(bus.enable_o), 1);
      check("st_data0", 32'(bus.data_o), 'h21);
      bus.stall_i = 1'b1;
      tick();
      check("st_gap1_en",   32'(bus.enable_o), 0);
      check("st_gap1_data", 32'(bus.data_o), 'h21);
      tick();
      check("st_gap2_en",   32'(bus.enable_o), 0);
      check("st_gap2_count", 32'(bus.fifo_count_o), 4);
      bus.stall_i = 1'b0;
      for (int i = 1; i < 5; i++) begin
         tick();
         check("st_en",   32'(bus.enable_o), 1);
         check("st_data", 32'(bus.data_o), 'h21 + i);
      end
      check("st_busy_end", 32'(bus.busy_o), 0);
      tick();
      check("st_en_after", 32'(bus.enable_o), 0);

      // Zero-length descriptor: consumed, nothing changes
      send_cfg(4'd4, 8'd0);
      check("z_cfgrdy", 32'(bus.cfg_ready_o), 1);
      check("z_mode",   32'(bus.router_mode_o), 6);
      check("z_busy",   32'(bus.busy_o), 0);
      tick();
      check("z_en",     32'(bus.enable_o), 0);
      check("z_busy2",  32'(bus.busy_o), 0);

      // Back-to-back bursts: WEST len 2 then EASTNORTH len 2
      for (int i = 0; i < 4; i++) push_word(16'('h31 + i));
      send_cfg(4'd3, 8'd2);
      check("bb_mode_a", 32'(bus.router_mode_o), 3);
      tick();
      tick();
      check("bb_a0_en",   32'(bus.enable_o), 1);
      check("bb_a0_data", 32'(bus.data_o), 'h31);
      tick();
      check("bb_a1_en",   32'(bus.enable_o), 1);
      check("bb_a1_data", 32'(bus.data_o), 'h32);
      check("bb_a1_mode", 32'(bus.router_mode_o), 3);
      check("bb_idle_rdy", 32'(bus.cfg_ready_o), 1);
      send_cfg(4'd5, 8'd2);
      check("bb_gap1_en",   32'(bus.enable_o), 0);
      check("bb_gap1_mode", 32'(bus.router_mode_o), 5);
      tick();
      check("bb_gap2_en", 32'(bus.enable_o), 0);
      tick();
      check("bb_b0_en",   32'(bus.enable_o), 1);
      check("bb_b0_data", 32'(bus.data_o), 'h33);
      tick();
      check("bb_b1_en",   32'(bus.enable_o), 1);
      check("bb_b1_data", 32'(bus.data_o), 'h34);
      check("bb_b1_busy", 32'(bus.busy_o), 0);

      // Reset in the middle of a 6-word burst
      for (int i = 0; i < 6; i++) push_word(16'('h41 + i));
      send_cfg(4'd9, 8'd6);
      tick();
      tick();
      check("mr_d0", 32'(bus.data_o), 'h41);
      tick();
      check("mr_d1", 32'(bus.data_o), 'h42);
      reset = 1'b1;
      tick();
      check("mr_busy",   32'(bus.busy_o), 0);
      check("mr_count",  32'(bus.fifo_count_o), 0);
      check("mr_en",     32'(bus.enable_o), 0);
      check("mr_mode",   32'(bus.router_mode_o), 0);
      check("mr_cfgrdy", 32'(bus.cfg_ready_o), 1);
      check("mr_data",   32'(bus.data_o), 0);
      reset = 1'b0;
      tick();
      check("mr_en_after",   32'(bus.enable_o), 0);
      check("mr_busy_after", 32'(bus.busy_o), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
